key_filter_array: RTL and testbench

//  Parametrised N-channel push-button debouncer: next generation of the team's single-key filter.
//  Per key: 2-FF sync, edge detect, 4-state debounce FSM, press/release pulses,

---
 rtl/key_filter_array_if.sv | 21 ++
 rtl/key_filter_array.sv | 143 ++++++++++++++
 tb/tb_key_filter_array.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/key_filter_array_if.sv
// rtl/key_filter_array_if.sv - key bank signal bundle: raw pins in, debounced level and event pulses out
interface key_filter_array_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_long;
    logic [NUM_KEYS-1:0] key_repeat;

    modport master (
        output key_in,
        input  key_press, key_release, key_state, key_long, key_repeat
    );

    modport slave (
        input  key_in,
        output key_press, key_release, key_state, key_long, key_repeat
    );
endinterface

// File: rtl/key_filter_array.sv
// rtl/key_filter_array.sv - N-channel key debouncer with press/release/long-press pulses
// Optional auto-repeat pulses are built only when KEY_REPEAT_EN is defined.
module key_filter_array #(
    parameter int NUM_KEYS   = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int FILTER_CNT = 1_000_000,
    parameter int LONG_CNT   = 50_000_000,
    parameter int REPEAT_CNT = 10_000_000,
    parameter int CNT_W      = 26
) (
    input  logic              clk,
    input  logic              rst,
    key_filter_array_if.slave keys
);
    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        FILTER0 = 4'b0010,
        DOWN    = 4'b0100,
        FILTER1 = 4'b1000
    } state_t;

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CNT - 1);

    logic [NUM_KEYS-1:0] r1, r2, r3;
    logic [NUM_KEYS-1:0] press_edge, rel_edge;
    logic [NUM_KEYS-1:0] press_q, release_q, state_q, long_q, fired;
    logic [NUM_KEYS-1:0] repeat_q;
    state_t              st  [NUM_KEYS];
    logic [CNT_W-1:0]    cnt [NUM_KEYS];
    logic [CNT_W-1:0]    rpt [NUM_KEYS];

    assign press_edge = r2 & ~r3;
    assign rel_edge   = ~r2 & r3;

    assign keys.key_press   = press_q;
    assign keys.key_release = release_q;
    assign keys.key_state   = state_q;
    assign keys.key_long    = long_q;

    // One counter per channel serves as filter counter in FILTER0/1 and hold counter in DOWN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1        <= '0;
            r2        <= '0;
            r3        <= '0;
            press_q   <= '0;
            release_q <= '0;
            state_q   <= '0;
            long_q    <= '0;
            fired     <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
                rpt[i] <= '0;
            end
        end else begin
            r1        <= (ACTIVE_LOW != 0) ? ~keys.key_in : keys.key_in;
            r2        <= r1;
            r3        <= r2;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                case (st[i])
                    IDLE: begin
                        if (press_edge[i]) begin
                            st[i]  <= FILTER0;
                            cnt[i] <= '0;
                        end
                    end
                    FILTER0: begin
                        if (cnt[i] == FILT_LAST) begin
                            st[i]      <= DOWN;
                            press_q[i] <= 1'b1;
                            state_q[i] <= 1'b1;
                            cnt[i]     <= '0;
                        end else if (rel_edge[i]) begin
                            st[i]  <= IDLE;
                            cnt[i] <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    DOWN: begin
                        if (rel_edge[i]) begin
                            st[i]  <= FILTER1;
                            cnt[i] <= '0;
                            rpt[i] <= '0;
                        end else begin
                            if (cnt[i] != LONG_LAST)
                                cnt[i] <= cnt[i] + 1'b1;
                            if (cnt[i] == LONG_LAST && !fired[i]) begin
                                long_q[i] <= 1'b1;
                                fired[i]  <= 1'b1;
                                rpt[i]    <= '0;
                            end else if (fired[i]) begin
                                // Repeat period runs from the long-press pulse onward.
                                if (rpt[i] == RPT_LAST) begin
                                    repeat_q[i] <= 1'b1;
                                    rpt[i]      <= '0;
                                end else begin
                                    rpt[i] <= rpt[i] + 1'b1;
                                end
                            end
                        end
                    end
                    FILTER1: begin
                        if (cnt[i] == FILT_LAST) begin
                            st[i]        <= IDLE;
                            release_q[i] <= 1'b1;
                            state_q[i]   <= 1'b0;
                            fired[i]     <= 1'b0;
                            cnt[i]       <= '0;
                        end else if (press_edge[i]) begin
                            st[i]  <= DOWN;
                            cnt[i] <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        st[i]  <= IDLE;
                        cnt[i] <= '0;
                    end
                endcase
            end
        end
    end

`ifdef KEY_REPEAT_EN
    assign keys.key_repeat = repeat_q;
`else
    // Repeat state is left unconnected here so synthesis trims it away.
    assign keys.key_repeat = '0;
    logic unused_repeat;
    assign unused_repeat = ^repeat_q ^ ^RPT_LAST;
`endif

endmodule

// File: tb/tb_key_filter_array.sv
// tb/tb_key_filter_array.sv - directed table-driven bench for key_filter_array
module tb_key_filter_array;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_filter_array_if #(.NUM_KEYS(4)) kif ();

    key_filter_array #(
        .NUM_KEYS(4), .ACTIVE_LOW(1), .FILTER_CNT(4),
        .LONG_CNT(16), .REPEAT_CNT(8), .CNT_W(26)
    ) dut (
        .clk (clk),
        .rst (rst),
        .keys(kif)
    );

`ifdef KEY_REPEAT_EN
    localparam logic [3:0] RPT3  = 4'b1000;
    localparam int         RPT_N = 4;
`else
    localparam logic [3:0] RPT3  = 4'b0000;
    localparam int         RPT_N = 0;
`endif

    typedef struct {
        bit         r;
        logic [3:0] key;
        int         n;
        logic [3:0] press, rel, state, lng, rpt;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    int   cnt_press[4], cnt_rel[4], cnt_long[4], cnt_rpt[4];
    int   both = 0;
    bit   mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < 4; c++) begin
                cnt_press[c] += int'(kif.key_press[c]);
                cnt_rel[c]   += int'(kif.key_release[c]);
                cnt_long[c]  += int'(kif.key_long[c]);
                cnt_rpt[c]   += int'(kif.key_repeat[c]);
                if (kif.key_press[c] && kif.key_release[c]) both++;
            end
        end
    end

    function automatic void add(bit r, logic [3:0] k, int n, logic [3:0] p, logic [3:0] rl,
                                logic [3:0] s, logic [3:0] l, logic [3:0] rp, string nm);
        vec_t v;
        v.r = r; v.key = k; v.n = n; v.press = p; v.rel = rl;
        v.state = s; v.lng = l; v.rpt = rp; v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic check_int(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            cnt_press[c] = 0; cnt_rel[c] = 0; cnt_long[c] = 0; cnt_rpt[c] = 0;
        end
        //   rst key   n   press  rel    state  long   repeat
        add(1, 4'hF, 2,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "reset");
        add(0, 4'hF, 2,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "idle");
        add(0, 4'hE, 6,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "t1_pre_press");
        add(0, 4'hE, 1,  4'h1, 4'h0, 4'h1, 4'h0, 4'h0, "t1_press");
        add(0, 4'hE, 1,  4'h0, 4'h0, 4'h1, 4'h0, 4'h0, "t1_press_end");
        add(0, 4'hE, 14, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, "t1_pre_long");
        add(0, 4'hE, 1,  4'h0, 4'h0, 4'h1, 4'h1, 4'h0, "t1_long");
        add(0, 4'hE, 1,  4'h0, 4'h0, 4'h1, 4'h0, 4'h0, "t1_long_end");
        add(0, 4'hF, 2,  4'h0, 4'h0, 4'h1, 4'h0, 4'h0, "t3_bounce_hi");
        add(0, 4'hE, 4,  4'h0, 4'h0, 4'h1, 4'h0, 4'h0, "t3_bounce_lo");
        add(0, 4'hF, 6,  4'h0, 4'h0, 4'h1, 4'h0, 4'h0, "t3_pre_release");
        add(0, 4'hF, 1,  4'h0, 4'h1, 4'h0, 4'h0, 4'h0, "t3_release");
        add(0, 4'hF, 1,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "t3_release_end");
        add(0, 4'hD, 3,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "t2_glitch");
        add(0, 4'hF, 8,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "t2_after");
        add(0, 4'h0, 6,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "t4_pre_press");
        add(0, 4'h0, 1,  4'hF, 4'h0, 4'hF, 4'h0, 4'h0, "t4_press_all");
        add(0, 4'h0, 1,  4'h0, 4'h0, 4'hF, 4'h0, 4'h0, "t4_press_end");
        add(0, 4'hF, 6,  4'h0, 4'h0, 4'hF, 4'h0, 4'h0, "t4_pre_release");
        add(0, 4'hF, 1,  4'h0, 4'hF, 4'h0, 4'h0, 4'h0, "t4_release_all");
        add(0, 4'hF, 2,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "t4_idle");
        add(0, 4'hB, 5,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "t5_filter0");
        add(1, 4'hB, 1,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "t5_reset_filter");
        add(0, 4'hB, 6,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "t5_refilter");
        add(0, 4'hB, 1,  4'h4, 4'h0, 4'h4, 4'h0, 4'h0, "t5_press");
        add(0, 4'hB, 3,  4'h0, 4'h0, 4'h4, 4'h0, 4'h0, "t5_hold");
        add(1, 4'hB, 1,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "t5_reset_hold");
        add(0, 4'hB, 6,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "t5_refilter2");
        add(0, 4'hB, 1,  4'h4, 4'h0, 4'h4, 4'h0, 4'h0, "t5_press2");
        add(0, 4'hF, 6,  4'h0, 4'h0, 4'h4, 4'h0, 4'h0, "t5_pre_release");
        add(0, 4'hF, 1,  4'h0, 4'h4, 4'h0, 4'h0, 4'h0, "t5_release");
        add(0, 4'h7, 6,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "t6_pre_press");
        add(0, 4'h7, 1,  4'h8, 4'h0, 4'h8, 4'h0, 4'h0, "t6_press");
        add(0, 4'h7, 15, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, "t6_pre_long");
        add(0, 4'h7, 1,  4'h0, 4'h0, 4'h8, 4'h8, 4'h0, "t6_long");
        for (int k = 0; k < 4; k++) begin
            add(0, 4'h7, 7, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, "t6_repeat_gap");
            add(0, 4'h7, 1, 4'h0, 4'h0, 4'h8, 4'h0, RPT3, "t6_repeat");
        end
        add(0, 4'hF, 6,  4'h0, 4'h0, 4'h8, 4'h0, 4'h0, "t6_pre_release");
        add(0, 4'hF, 1,  4'h0, 4'h8, 4'h0, 4'h0, 4'h0, "t6_release");
        add(0, 4'hF, 10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "t6_quiet");

        rst        = 1'b1;
        kif.key_in = 4'hF;
        for (int i = 0; i < vecs.size(); i++) begin
            logic [19:0] act, exp;
            rst        = vecs[i].r;
            kif.key_in = vecs[i].key;
            repeat (vecs[i].n) begin
                @(posedge clk);
                #1;
            end
            mon_en = 1'b1;
            act = {kif.key_press, kif.key_release, kif.key_state, kif.key_long, kif.key_repeat};
            exp = {vecs[i].press, vecs[i].rel, vecs[i].state, vecs[i].lng, vecs[i].rpt};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: press/rel/state/long/rpt got %h expected %h",
                         vecs[i].name, act, exp);
            end
        end

        check_int("press_count_0",   cnt_press[0], 2);
        check_int("press_count_1",   cnt_press[1], 1);
        check_int("press_count_2",   cnt_press[2], 3);
        check_int("press_count_3",   cnt_press[3], 2);
        check_int("release_count_0", cnt_rel[0], 2);
        check_int("release_count_1", cnt_rel[1], 1);
        check_int("release_count_2", cnt_rel[2], 2);
        check_int("release_count_3", cnt_rel[3], 2);
        check_int("long_count_0",    cnt_long[0], 1);
        check_int("long_count_1",    cnt_long[1], 0);
        check_int("long_count_2",    cnt_long[2], 0);
        check_int("long_count_3",    cnt_long[3], 1);
        check_int("repeat_count_0",  cnt_rpt[0], 0);
        check_int("repeat_count_3",  cnt_rpt[3], RPT_N);
        check_int("press_release_same_cycle", both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
